// File: rtl/mux2_rr_arb.sv
// -----------------------------------------------------------------------------
// mux2_rr_arb
//
// Two-channel round-robin arbiter with an output register stage. Channels A
// and B present valid/ready words. One word per beat is chosen and registered
// together with its source select (0 = A, 1 = B). The select uses the same
// encoding as the downstream 2:1 mux sel input, so it can drive that input
// directly. A channel may hold the grant for up to BURST consecutive beats
// while the other channel is waiting.
//
// Parameters
//   WIDTH      data width of each channel and of the output
//   BURST      max consecutive grants to one channel under contention (1..15)
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   a_valid_i    channel A word available
//   a_data_i     channel A word
//   a_ready_o    channel A word is taken this cycle
//   b_valid_i    channel B word available
//   b_data_i     channel B word
//   b_ready_o    channel B word is taken this cycle
//   out_valid_o  output register holds a word
//   out_data_o   registered winning word
//   out_sel_o    registered source of out_data_o (0 = A, 1 = B)
//   out_ready_i  downstream accepts the output word
// -----------------------------------------------------------------------------
module mux2_rr_arb #(
  parameter int WIDTH = 4,
  parameter int BURST = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_sel_o,
  input  logic             out_ready_i
);

  localparam logic [3:0] BURST_MAX = 4'(BURST - 1);
  localparam logic       SEL_A     = 1'b0;
  localparam logic       SEL_B     = 1'b1;

  // Output register and arbitration state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_sel_q,   out_sel_d;
  logic             owner_q,     owner_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  // Set once any word has been granted. Out of reset there is no live run,
  // so contention rotates away from the reset owner (B), letting A win first.
  logic             owner_vld_q, owner_vld_d;

  logic             load_s;
  logic             grant_vld_s;
  logic             grant_sel_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             xfer_s;

  // Output register may accept a word when empty or being drained this cycle
  assign load_s = !out_valid_q || out_ready_i;
  assign xfer_s = load_s && grant_vld_s;

  // Grant decision: single requester wins; under contention hold the owner
  // while its run is shorter than BURST, otherwise rotate
  always_comb begin
    grant_vld_s = 1'b0;
    grant_sel_s = SEL_A;
    case ({a_valid_i, b_valid_i})
      2'b10: begin
        grant_vld_s = 1'b1;
        grant_sel_s = SEL_A;
      end
      2'b01: begin
        grant_vld_s = 1'b1;
        grant_sel_s = SEL_B;
      end
      2'b11: begin
        grant_vld_s = 1'b1;
        if (owner_vld_q && (burst_cnt_q < BURST_MAX)) begin
          grant_sel_s = owner_q;
        end else begin
          grant_sel_s = ~owner_q;
        end
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_sel_s = SEL_A;
      end
    endcase
  end

  // Granted word selection
  always_comb begin
    if (grant_sel_s == SEL_B) begin
      grant_data_s = b_data_i;
    end else begin
      grant_data_s = a_data_i;
    end
  end

  // Readies: only the granted channel, only when the register can load.
  // Gated by rst_ni so no source sees a handshake while reset is asserted.
  always_comb begin
    if (rst_ni && xfer_s) begin
      a_ready_o = (grant_sel_s == SEL_A);
      b_ready_o = (grant_sel_s == SEL_B);
    end else begin
      a_ready_o = 1'b0;
      b_ready_o = 1'b0;
    end
  end

  // Next-state for output register and arbitration state
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    owner_vld_d = owner_vld_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_s;
      out_sel_d   = grant_sel_s;
      owner_vld_d = 1'b1;
      if (owner_vld_q && (grant_sel_s == owner_q)) begin
        // Same channel again: extend the run, saturating at BURST-1
        if (burst_cnt_q < BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = BURST_MAX;
        end
      end else begin
        owner_d     = grant_sel_s;
        burst_cnt_d = 4'd0;
      end
    end else if (load_s) begin
      // Register drained (or empty) with nothing to load: go empty
      out_valid_d = 1'b0;
    end else begin
      // Backpressure: hold everything
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      owner_q     <= 1'b1;
      burst_cnt_q <= 4'd0;
      owner_vld_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      owner_vld_q <= owner_vld_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux2_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux2_rr_arb
//
// Directed self-checking bench for mux2_rr_arb. Two instances: dut (BURST=2)
// and dut1 (BURST=1). Inputs change at posedge+1, readies are sampled on the
// falling edge, registered outputs at posedge+1.
// -----------------------------------------------------------------------------
module tb_mux2_rr_arb;

  logic       clk;
  logic       rst_n;

  logic       a_valid, b_valid, a_ready, b_ready;
  logic [3:0] a_data, b_data;
  logic       out_valid, out_sel, out_ready;
  logic [3:0] out_data;

  logic       a1_valid, b1_valid, a1_ready, b1_ready;
  logic [3:0] a1_data, b1_data;
  logic       out1_valid, out1_sel, out1_ready;
  logic [3:0] out1_data;

  int n_tests;
  int n_fail;

  mux2_rr_arb #(.WIDTH(4), .BURST(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_sel_o(out_sel),
    .out_ready_i(out_ready)
  );

  mux2_rr_arb #(.WIDTH(4), .BURST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a1_valid), .a_data_i(a1_data), .a_ready_o(a1_ready),
    .b_valid_i(b1_valid), .b_data_i(b1_data), .b_ready_o(b1_ready),
    .out_valid_o(out1_valid), .out_data_o(out1_data), .out_sel_o(out1_sel),
    .out_ready_i(out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset both instances; ends at posedge+1 with reset released
  task automatic apply_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 4'd0; b_data = 4'd0; out_ready = 1'b1;
    a1_valid = 1'b0; b1_valid = 1'b0; a1_data = 4'd0; b1_data = 4'd0; out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 4'd3;
    b_valid = 1'b1; b_data = 4'd7;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got a=%b b=%b, want 0 0", a_ready, b_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%b d=%0d s=%b, want 0 0 0", out_valid, out_data, out_sel);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_grant: got a=%b b=%b, want 1 0", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd3 || out_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_word: got v=%b d=%0d s=%b, want 1 3 0", out_valid, out_data, out_sel);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_single();
    logic ar;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1; a_data = 4'(k + 1); b_valid = 1'b0;
      @(negedge clk);
      ar = a_ready;
      n_tests++;
      if (ar !== 1'b1 || b_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_ready[%0d]: got a=%b b=%b, want 1 0", k, ar, b_ready);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 4'(k + 1) || out_sel !== 1'b0) begin
        n_fail++;
        $display("FAIL single_out[%0d]: got v=%b d=%0d s=%b, want 1 %0d 0",
                 k, out_valid, out_data, out_sel, k + 1);
      end
    end
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_d [8] = '{4'd1, 4'd2, 4'd8, 4'd9, 4'd3, 4'd4, 4'd10, 4'd11};
    logic       exp_s [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int ai;
    int bi;
    logic ar, br;
    ai = 0; bi = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1; a_data = 4'(ai + 1);
      b_valid = 1'b1; b_data = 4'(bi + 8);
      out_ready = 1'b1;
      @(negedge clk);
      ar = a_ready; br = b_ready;
      n_tests++;
      if ((ar ^ br) !== 1'b1) begin
        n_fail++;
        $display("FAIL cont_onehot[%0d]: got a=%b b=%b, want exactly one", k, ar, br);
      end
      @(posedge clk);
      #1;
      if (ar) ai++;
      if (br) bi++;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_sel !== exp_s[k]) begin
        n_fail++;
        $display("FAIL cont_out[%0d]: got v=%b d=%0d s=%b, want 1 %0d %b",
                 k, out_valid, out_data, out_sel, exp_d[k], exp_s[k]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_burst1();
    logic [3:0] exp_d [6] = '{4'd1, 4'd8, 4'd2, 4'd9, 4'd3, 4'd10};
    logic       exp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int ai;
    int bi;
    logic ar, br;
    ai = 0; bi = 0;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      a1_valid = 1'b1; a1_data = 4'(ai + 1);
      b1_valid = 1'b1; b1_data = 4'(bi + 8);
      out1_ready = 1'b1;
      @(negedge clk);
      ar = a1_ready; br = b1_ready;
      @(posedge clk);
      #1;
      if (ar) ai++;
      if (br) bi++;
      n_tests++;
      if (out1_valid !== 1'b1 || out1_data !== exp_d[k] || out1_sel !== exp_s[k]) begin
        n_fail++;
        $display("FAIL burst1_out[%0d]: got v=%b d=%0d s=%b, want 1 %0d %b",
                 k, out1_valid, out1_data, out1_sel, exp_d[k], exp_s[k]);
      end
    end
    a1_valid = 1'b0; b1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    a_valid = 1'b1; a_data = 4'd5; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd5) begin
      n_fail++;
      $display("FAIL bp_load: got v=%b d=%0d, want 1 5", out_valid, out_data);
    end
    a_data = 4'd6; b_valid = 1'b1; b_data = 4'd12; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got a=%b b=%b, want 0 0", k, a_ready, b_ready);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 4'd5 || out_sel !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%b, want 1 5 0", k, out_valid, out_data, out_sel);
      end
    end
    // Drain and load together; A still holds its run (1 beat so far)
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_ready: got a=%b b=%b, want 1 0", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd6 || out_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_out: got v=%b d=%0d s=%b, want 1 6 0", out_valid, out_data, out_sel);
    end
    // A's run reached BURST beats, so waiting B is granted next
    a_data = 4'd7;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd12 || out_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rotate: got v=%b d=%0d s=%b, want 1 12 1", out_valid, out_data, out_sel);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    // Make B the owner with a live run
    b_valid = 1'b1; b_data = 4'd9; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd9 || out_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: got v=%b d=%0d s=%b, want 1 9 1", out_valid, out_data, out_sel);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_async_drop: got v=%b, want 0", out_valid);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b1; a_data = 4'd2;
    b_valid = 1'b1; b_data = 4'd12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_restart_ready: got a=%b b=%b, want 1 0", a_ready, b_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 4'd2 || out_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_restart_out: got v=%b d=%0d s=%b, want 1 2 0", out_valid, out_data, out_sel);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 4'd0; b_data = 4'd0; out_ready = 1'b1;
    a1_valid = 1'b0; b1_valid = 1'b0; a1_data = 4'd0; b1_data = 4'd0; out1_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_burst1();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
